// File: rtl/cfg_info_responder.sv
// cfg_info_responder: read-only configuration discovery responder.
// The elaborated core configuration is flattened into a constant table of
// 32-bit words. Single indexed reads use a valid/ready request/response
// channel, and a dump mode streams the whole table in index order.
// Optional feature macro: CFG_INFO_WORLDGUARD_EN. When it is defined, a
// WorldGuard word is inserted at index 7 and the checksum moves to index 8.

package config_pkg;

  // Subset of the core configuration that is reported by the responder.
  typedef struct packed {
    logic [31:0] XLEN;
    logic [31:0] PLEN;
    logic [31:0] VLEN;
    logic [31:0] FLen;
    logic        RVA;
    logic        RVB;
    logic        RVC;
    logic        RVD;
    logic        RVF;
    logic        RVH;
    logic        RVS;
    logic        RVU;
    logic        RVV;
    logic        ZKN;
    logic        RVZCB;
    logic        RVZCMP;
    logic        RVZiCond;
    logic        RVZicntr;
    logic        RVZihpm;
    logic        CvxifEn;
    logic        FpPresent;
    logic        MmuPresent;
    logic        DebugEn;
    logic        SuperscalarEn;
    logic [31:0] ICACHE_LINE_WIDTH;
    logic [31:0] ICACHE_INDEX_WIDTH;
    logic [31:0] ICACHE_SET_ASSOC;
    logic [31:0] DCACHE_LINE_WIDTH;
    logic [31:0] DCACHE_INDEX_WIDTH;
    logic [31:0] DCACHE_SET_ASSOC;
    logic [31:0] NR_SB_ENTRIES;
    logic [31:0] NrPMPEntries;
    logic [31:0] DataTlbEntries;
    logic [31:0] InstrTlbEntries;
    logic [31:0] NrWbPorts;
    logic [31:0] NrIssuePorts;
    logic [31:0] NrCommitPorts;
    logic [31:0] WG_MWID_LIST;
    logic [31:0] WG_ID_WIDTH;
    logic        WgSHWGEn;
    logic        WgSSWGEn;
    logic        WgSMWGEn;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

endpackage

module cfg_info_responder #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg  = config_pkg::cva6_cfg_empty,
  parameter int unsigned           IdxWidth = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [IdxWidth-1:0] req_idx_i,
  input  logic                dump_start_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_data_o,
  output logic [IdxWidth-1:0] rsp_idx_o,
  output logic                rsp_err_o,
  output logic                rsp_last_o,
  output logic                dump_busy_o
);

  // ---------------------------------------------------------------------
  // Constant word table, built at elaboration; every field is truncated
  // to the width of its slot.
  // ---------------------------------------------------------------------
  localparam logic [31:0] W0 = 32'h43564136;
  localparam logic [31:0] W1 = {CVA6Cfg.FLen[7:0], CVA6Cfg.VLEN[7:0],
                                CVA6Cfg.PLEN[7:0], CVA6Cfg.XLEN[7:0]};
  localparam logic [31:0] W2 = {12'h000,
                                CVA6Cfg.SuperscalarEn, CVA6Cfg.DebugEn,
                                CVA6Cfg.MmuPresent, CVA6Cfg.FpPresent,
                                CVA6Cfg.CvxifEn, CVA6Cfg.RVZihpm,
                                CVA6Cfg.RVZicntr, CVA6Cfg.RVZiCond,
                                CVA6Cfg.RVZCMP, CVA6Cfg.RVZCB,
                                CVA6Cfg.ZKN, CVA6Cfg.RVV,
                                CVA6Cfg.RVU, CVA6Cfg.RVS,
                                CVA6Cfg.RVH, CVA6Cfg.RVF,
                                CVA6Cfg.RVD, CVA6Cfg.RVC,
                                CVA6Cfg.RVB, CVA6Cfg.RVA};
  localparam logic [31:0] W3 = {CVA6Cfg.ICACHE_LINE_WIDTH[15:0],
                                CVA6Cfg.ICACHE_INDEX_WIDTH[7:0],
                                CVA6Cfg.ICACHE_SET_ASSOC[7:0]};
  localparam logic [31:0] W4 = {CVA6Cfg.DCACHE_LINE_WIDTH[15:0],
                                CVA6Cfg.DCACHE_INDEX_WIDTH[7:0],
                                CVA6Cfg.DCACHE_SET_ASSOC[7:0]};
  localparam logic [31:0] W5 = {CVA6Cfg.NR_SB_ENTRIES[7:0],
                                CVA6Cfg.NrPMPEntries[7:0],
                                CVA6Cfg.DataTlbEntries[7:0],
                                CVA6Cfg.InstrTlbEntries[7:0]};
  localparam logic [31:0] W6 = {8'h00, CVA6Cfg.NrWbPorts[7:0],
                                CVA6Cfg.NrIssuePorts[7:0],
                                CVA6Cfg.NrCommitPorts[7:0]};

`ifdef CFG_INFO_WORLDGUARD_EN
  localparam int unsigned NumWords = 9;
  localparam logic [31:0] W7 = {8'h00, CVA6Cfg.WG_MWID_LIST[7:0],
                                CVA6Cfg.WG_ID_WIDTH[7:0], 5'h00,
                                CVA6Cfg.WgSHWGEn, CVA6Cfg.WgSSWGEn,
                                CVA6Cfg.WgSMWGEn};
  localparam logic [31:0] W8 = W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5 ^ W6 ^ W7;
`else
  localparam int unsigned NumWords = 8;
  localparam logic [31:0] W7 = W0 ^ W1 ^ W2 ^ W3 ^ W4 ^ W5 ^ W6;
`endif

  // Table lookup; indices past the table read as zero.
  function automatic logic [31:0] word_at(input logic [IdxWidth-1:0] idx);
    case (32'(idx))
      32'd0:   return W0;
      32'd1:   return W1;
      32'd2:   return W2;
      32'd3:   return W3;
      32'd4:   return W4;
      32'd5:   return W5;
      32'd6:   return W6;
      32'd7:   return W7;
`ifdef CFG_INFO_WORLDGUARD_EN
      32'd8:   return W8;
`endif
      default: return 32'h0;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RSP  = 2'd1,
    DUMP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic [IdxWidth-1:0] rsp_idx_q, rsp_idx_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_last_q, rsp_last_d;
  logic                dump_busy_q, dump_busy_d;

  logic                rsp_hs;
  logic                req_in_range;
  logic [IdxWidth-1:0] idx_inc;

  assign rsp_hs       = rsp_valid_q & rsp_ready_i;
  assign req_in_range = 32'(req_idx_i) < NumWords;
  // The dump walks the table using the index register it reports.
  assign idx_inc      = rsp_idx_q + IdxWidth'(1);

  // State register plus the registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_idx_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_last_q  <= 1'b0;
      dump_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_err_q   <= rsp_err_d;
      rsp_last_q  <= rsp_last_d;
      dump_busy_q <= dump_busy_d;
    end
  end

  // Next-state selection; a dump request wins over a single read in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          state_d = DUMP;
        end else if (req_valid_i) begin
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      DUMP: begin
        if (rsp_hs && rsp_last_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the response registers; everything holds while stalled.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_idx_d   = rsp_idx_q;
    rsp_err_d   = rsp_err_q;
    rsp_last_d  = rsp_last_q;
    dump_busy_d = dump_busy_q;
    case (state_q)
      IDLE: begin
        if (dump_start_i) begin
          rsp_valid_d = 1'b1;
          rsp_idx_d   = '0;
          rsp_data_d  = W0;
          rsp_err_d   = 1'b0;
          rsp_last_d  = 1'b0;
          dump_busy_d = 1'b1;
        end else if (req_valid_i) begin
          rsp_valid_d = 1'b1;
          rsp_idx_d   = req_idx_i;
          rsp_data_d  = req_in_range ? word_at(req_idx_i) : 32'h0;
          rsp_err_d   = ~req_in_range;
          rsp_last_d  = 1'b0;
          dump_busy_d = 1'b0;
        end
      end
      RSP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
        end
      end
      DUMP: begin
        if (rsp_hs) begin
          if (rsp_last_q) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
            dump_busy_d = 1'b0;
          end else begin
            rsp_idx_d  = idx_inc;
            rsp_data_d = word_at(idx_inc);
            rsp_last_d = (32'(idx_inc) == NumWords - 1);
          end
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_last_o  = rsp_last_q;
  assign dump_busy_o = dump_busy_q;

endmodule

// File: tb/tb_cfg_info_responder.sv
// Directed testbench for cfg_info_responder with an XLEN=64 / PLEN=56
// configuration. Inputs change on the falling edge and outputs are sampled
// there too, half a period away from the active rising edge.
// Honours CFG_INFO_WORLDGUARD_EN for the expected table.

module tb_cfg_info_responder;

  localparam int unsigned IdxWidth = 4;

  function automatic config_pkg::cva6_cfg_t make_cfg();
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.XLEN = 32'd64;  c.PLEN = 32'd56;  c.VLEN = 32'd128;  c.FLen = 32'd64;
    c.RVA = 1'b1;  c.RVB = 1'b0;  c.RVC = 1'b1;  c.RVD = 1'b1;
    c.RVF = 1'b1;  c.RVH = 1'b0;  c.RVS = 1'b1;  c.RVU = 1'b1;
    c.RVV = 1'b0;  c.ZKN = 1'b1;  c.RVZCB = 1'b1;  c.RVZCMP = 1'b0;
    c.RVZiCond = 1'b1;  c.RVZicntr = 1'b1;  c.RVZihpm = 1'b0;  c.CvxifEn = 1'b1;
    c.FpPresent = 1'b1;  c.MmuPresent = 1'b1;  c.DebugEn = 1'b1;
    c.SuperscalarEn = 1'b0;
    c.ICACHE_LINE_WIDTH = 32'd128;  c.ICACHE_INDEX_WIDTH = 32'd12;
    c.ICACHE_SET_ASSOC = 32'd4;
    c.DCACHE_LINE_WIDTH = 32'd128;  c.DCACHE_INDEX_WIDTH = 32'd12;
    c.DCACHE_SET_ASSOC = 32'd8;
    c.NR_SB_ENTRIES = 32'd8;  c.NrPMPEntries = 32'd16;
    c.DataTlbEntries = 32'd16;  c.InstrTlbEntries = 32'd2;
    c.NrWbPorts = 32'd4;  c.NrIssuePorts = 32'd1;  c.NrCommitPorts = 32'd2;
    c.WG_MWID_LIST = 32'd3;  c.WG_ID_WIDTH = 32'd2;
    c.WgSHWGEn = 1'b1;  c.WgSSWGEn = 1'b0;  c.WgSMWGEn = 1'b1;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TbCfg = make_cfg();

  // Hand-computed expected words for TbCfg.
`ifdef CFG_INFO_WORLDGUARD_EN
  localparam int NW = 9;
  localparam logic [31:0] EXP [9] = '{32'h43564136, 32'h40803840, 32'h0007B6DD,
                                      32'h00800C04, 32'h00800C08, 32'h08101002,
                                      32'h00040102, 32'h00030205, 32'h0BC6DCA2};
`else
  localparam int NW = 8;
  localparam logic [31:0] EXP [8] = '{32'h43564136, 32'h40803840, 32'h0007B6DD,
                                      32'h00800C04, 32'h00800C08, 32'h08101002,
                                      32'h00040102, 32'h0BC5DEA7};
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [IdxWidth-1:0] req_idx = '0;
  logic                dump_start = 1'b0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [31:0]         rsp_data;
  logic [IdxWidth-1:0] rsp_idx;
  logic                rsp_err;
  logic                rsp_last;
  logic                dump_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cfg_info_responder #(
    .CVA6Cfg  (TbCfg),
    .IdxWidth (IdxWidth)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_idx_i    (req_idx),
    .dump_start_i (dump_start),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_idx_o    (rsp_idx),
    .rsp_err_o    (rsp_err),
    .rsp_last_o   (rsp_last),
    .dump_busy_o  (dump_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_data"},  rsp_data,       32'd0);
    check({tag, " rsp_idx"},   32'(rsp_idx),   32'd0);
    check({tag, " rsp_err"},   32'(rsp_err),   32'd0);
    check({tag, " rsp_last"},  32'(rsp_last),  32'd0);
    check({tag, " dump_busy"}, 32'(dump_busy), 32'd0);
  endtask

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] xsum;
    int          exp_idx;
    bit          done;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // ---- single read idx 0, 1-cycle latency ----
    req_valid = 1'b1; req_idx = 4'd0; rsp_ready = 1'b1;
    @(negedge clk);
    $display("[TB] read idx 0");
    check("rd0 valid", 32'(rsp_valid), 32'd1);
    check("rd0 data", rsp_data, 32'h43564136);
    check("rd0 err", 32'(rsp_err), 32'd0);
    check("rd0 req_ready busy", 32'(req_ready), 32'd0);
    req_idx = 4'd1;
    @(negedge clk);
    check("rd0 valid drop", 32'(rsp_valid), 32'd0);
    check("rd0 back in idle", 32'(req_ready), 32'd1);

    // ---- second request accepted two cycles after the first ----
    @(negedge clk);
    $display("[TB] read idx 1");
    check("rd1 valid", 32'(rsp_valid), 32'd1);
    check("rd1 idx", 32'(rsp_idx), 32'd1);
    check("rd1 xlen byte", 32'(rsp_data[7:0]), 32'h40);
    check("rd1 plen byte", 32'(rsp_data[15:8]), 32'h38);
    check("rd1 word", rsp_data, EXP[1]);
    req_idx = 4'd12;
    @(negedge clk);
    check("rd1 valid drop", 32'(rsp_valid), 32'd0);

    // ---- out-of-range read ----
    @(negedge clk);
    $display("[TB] read idx 12");
    check("rd12 valid", 32'(rsp_valid), 32'd1);
    check("rd12 data", rsp_data, 32'd0);
    check("rd12 err", 32'(rsp_err), 32'd1);
    check("rd12 idx", 32'(rsp_idx), 32'd12);
    req_valid = 1'b0;
    @(negedge clk);
    check("rd12 valid drop", 32'(rsp_valid), 32'd0);

    // ---- first index past the table (8 without WorldGuard) ----
    req_valid = 1'b1; req_idx = 4'(NW);
    @(negedge clk);
    $display("[TB] read idx %0d (one past table)", NW);
    check("rdNW err", 32'(rsp_err), 32'd1);
    check("rdNW data", rsp_data, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);

    // ---- stalled read of idx 3; a dump pulse mid-stall is ignored ----
    req_valid = 1'b1; req_idx = 4'd3; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      $display("[TB] stall cycle %0d idx=%0d data=%h", i, rsp_idx, rsp_data);
      check("stall valid", 32'(rsp_valid), 32'd1);
      check("stall data", rsp_data, EXP[3]);
      check("stall idx", 32'(rsp_idx), 32'd3);
      check("stall req_ready", 32'(req_ready), 32'd0);
      dump_start = (i == 1);
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    check("stall released valid", 32'(rsp_valid), 32'd0);
    check("stall released idle", 32'(req_ready), 32'd1);
    check("stall dump ignored", 32'(dump_busy), 32'd0);

    // ---- dump and request together: dump wins, back-to-back words ----
    dump_start = 1'b1; req_valid = 1'b1; req_idx = 4'd5; rsp_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0; req_valid = 1'b0;
    xsum = 32'h0;
    for (int k = 0; k < NW; k++) begin
      $display("[TB] dump idx=%0d data=%h last=%0d", rsp_idx, rsp_data, rsp_last);
      check("dump valid", 32'(rsp_valid), 32'd1);
      check("dump idx", 32'(rsp_idx), 32'(k));
      check("dump data", rsp_data, EXP[k]);
      check("dump last", 32'(rsp_last), 32'(k == NW - 1));
      check("dump busy", 32'(dump_busy), 32'd1);
      check("dump err", 32'(rsp_err), 32'd0);
      if (k < NW - 1) xsum = xsum ^ rsp_data;
      else check("dump checksum", rsp_data, xsum);
      @(negedge clk);
    end
    check("dump end valid", 32'(rsp_valid), 32'd0);
    check("dump end busy", 32'(dump_busy), 32'd0);
    check("dump end idle", 32'(req_ready), 32'd1);
    check("dump request not served", 32'(rsp_valid), 32'd0);

    // ---- dump under random back-pressure ----
    dump_start = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    dump_start = 1'b0;
    exp_idx = 0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      check("rnd valid", 32'(rsp_valid), 32'd1);
      check("rnd idx", 32'(rsp_idx), 32'(exp_idx));
      check("rnd data", rsp_data, EXP[exp_idx % NW]);
      rsp_ready = (cyc >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      if (rsp_ready) begin
        $display("[TB] rnd handshake idx=%0d data=%h", rsp_idx, rsp_data);
        if (rsp_last) done = 1'b1;
        else exp_idx++;
      end
      @(negedge clk);
    end
    check("rnd completed", 32'(done), 32'd1);
    check("rnd word count", 32'(exp_idx), 32'(NW - 1));
    check("rnd busy fall", 32'(dump_busy), 32'd0);
    check("rnd valid fall", 32'(rsp_valid), 32'd0);

    // ---- reset mid-dump at index 4 with a stalled response ----
    dump_start = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid idx before reset", 32'(rsp_idx), 32'd4);
    rsp_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset mid-dump");
    check_reset_outputs("mid-dump reset");
    rst = 1'b0; dump_start = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    dump_start = 1'b0;
    $display("[TB] restart dump idx=%0d data=%h", rsp_idx, rsp_data);
    check("restart valid", 32'(rsp_valid), 32'd1);
    check("restart idx", 32'(rsp_idx), 32'd0);
    check("restart data", rsp_data, EXP[0]);
    check("restart busy", 32'(dump_busy), 32'd1);
    repeat (NW) @(negedge clk);
    check("restart finished", 32'(dump_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cfg_info_responder.md
Name: cfg_info_responder

Overview:
- Read-only configuration discovery responder. It exposes the elaborated core configuration (the cva6_cfg_t consumed by every block) as indexed 32-bit words to debug or software.
- Serves single indexed reads over a valid/ready request/response channel.
- Also provides a streaming dump mode that emits the whole word table in order.
- Sits beside the CSR file / debug module. It is the consumer side of configuration building: it turns the config struct back into a wire-readable table.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty, elaborated core configuration to report.
- IdxWidth, 4, width of the request index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- req_valid_i  in  1  single-read request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_idx_i  in  IdxWidth  word index to read
- dump_start_i  in  1  pulse: stream all words
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  32  word data
- rsp_idx_o  out  IdxWidth  index of the word in rsp_data_o
- rsp_err_o  out  1  index out of range
- rsp_last_o  out  1  final word of a dump
- dump_busy_o  out  1  dump in progress

Behaviour:
- Word table: constants derived from CVA6Cfg at elaboration. No runtime storage of config.
  - W0 = 32'h43564136.
  - W1 = {FLen[7:0], VLEN[7:0], PLEN[7:0], XLEN[7:0]}.
  - W2 flags, one per bit:
    - bits 0-7: RVA, RVB, RVC, RVD, RVF, RVH, RVS, RVU
    - bits 8-15: RVV, ZKN, RVZCB, RVZCMP, RVZiCond, RVZicntr, RVZihpm, CvxifEn
    - bits 16-19: FpPresent, MmuPresent, DebugEn, SuperscalarEn
    - bits 31:20 = 0
  - W3 = {ICACHE_LINE_WIDTH[15:0], ICACHE_INDEX_WIDTH[7:0], ICACHE_SET_ASSOC[7:0]}.
  - W4 = same layout as W3, for the dcache.
  - W5 = {NR_SB_ENTRIES[7:0], NrPMPEntries[7:0], DataTlbEntries[7:0], InstrTlbEntries[7:0]}.
  - W6 = {8'h0, NrWbPorts[7:0], NrIssuePorts[7:0], NrCommitPorts[7:0]}.
  - W7 = XOR of W0..W6 (checksum).
  - NumWords = 8. Each field is truncated to its slot width.
- FSM states: IDLE, RSP, DUMP.
- Reset: state IDLE.
  - Outputs: req_ready_o=1; rsp_valid_o, rsp_err_o, rsp_last_o, dump_busy_o = 0; rsp_data_o=0; rsp_idx_o=0.
- Outputs are registered, except req_ready_o = (state==IDLE).
- IDLE:
  - dump_start_i=1 → DUMP with index 0. Takes priority over req_valid_i in the same cycle; that request is not accepted.
  - Otherwise, req_valid_i=1 → latch the index and go to RSP.
  - rsp_valid_o rises the cycle after acceptance (1-cycle latency).
- RSP:
  - rsp_data_o = W[idx], or 0 with rsp_err_o=1 if idx >= NumWords.
  - Data/idx/err are held stable while rsp_valid_o=1 and rsp_ready_i=0.
  - On handshake → IDLE; rsp_valid_o drops the next cycle.
  - Maximum single-read throughput: one word per 2 cycles.
- DUMP:
  - dump_busy_o=1. Emits W0..W(NumWords-1) in order, rsp_err_o=0.
  - The index advances on each handshake, so back-to-back words are possible at one word per cycle when rsp_ready_i stays high.
  - rsp_last_o=1 only with the final word. Its handshake → IDLE.
- dump_start_i outside IDLE is ignored.
- Reset asserted in any state (including mid-dump with a stalled response) → IDLE next cycle. The response is dropped with no further handshake.
- No combinational path from rsp_ready_i to rsp_valid_o or rsp_data_o.

Optional Feature:
- Macro: CFG_INFO_WORLDGUARD_EN.
- Defined:
  - W7 = {8'h0, WG_MWID_LIST[7:0], WG_ID_WIDTH[7:0], 5'h0, WgSHWGEn, WgSSWGEn, WgSMWGEn}.
  - Checksum moves to W8 (XOR of W0..W7).
  - NumWords=9; index 8 is the last word of a dump.
- Undefined: table as above, NumWords=8. Index 8 returns err.

Test Plan:
- XLEN=64/PLEN=56 config; read idx 0 with rsp_ready_i=1 → rsp_valid_o the cycle after acceptance, data 32'h43564136, err 0; the next request is accepted two cycles after the first.
- Same config, read idx 1 → rsp_data_o[7:0]=8'h40, [15:8]=8'h38; read idx 12 → rsp_data_o=0, rsp_err_o=1, rsp_idx_o=12.
- Read idx 3 while holding rsp_ready_i=0 for 5 cycles → rsp_valid_o, data and idx held constant; req_ready_o=0 throughout; handshake on cycle 6 → IDLE.
- dump_start_i and req_valid_i high in the same cycle → dump runs, request not accepted; with rsp_ready_i=1, indices 0..7 appear on consecutive cycles, rsp_last_o only on 7, checksum = XOR of observed words 0..6.
- Random rsp_ready_i stalls during a dump → no word skipped or duplicated; dump_busy_o falls the cycle after the last handshake.
- rst_i asserted mid-dump at index 4 → next cycle all outputs at reset values; a new dump restarts at index 0.
